// File: rtl/fifo_8x8.sv
// fifo_8x8: single-clock 8x8 FIFO with registered read data and full/empty flags.
// Flags are registered copies of the decoded next count, so every output is a flop.
module fifo_8x8 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  wr,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  wr_ok_c, rd_ok_c;

  // Accept decisions, storage/pointer/count updates and next flag values.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    d_out_d  = d_out_q;

    wr_ok_c = wr & ~full_q;
    rd_ok_c = rd & ~empty_q;

    if (wr_ok_c) begin
      mem_d[wr_ptr_q] = d_in;
      wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
    end

    if (rd_ok_c) begin
      d_out_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    case ({wr_ok_c, rd_ok_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
  end

  // Control state with synchronous reset; queued data is discarded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      d_out_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      d_out_q  <= d_out_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents survive reset, writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

  assign d_out = d_out_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: tb/tb_fifo_8x8.sv
// tb_fifo_8x8: directed plan plus random traffic against a queue-based FIFO model.
module tb_fifo_8x8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d_in;
  logic       wr;
  logic       rd;
  logic [7:0] d_out;
  logic       empty;
  logic       full;

  int total = 0;
  int bad   = 0;

  fifo_8x8 dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .wr    (wr),
    .rd    (rd),
    .d_out (d_out),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  // Behavioural model: a byte queue bounded at 8, plus the last value read.
  logic [7:0] q [$];
  logic [7:0] exp_dout = 8'h00;
  bit         model_valid = 1'b0;

  always @(posedge clk) begin
    bit w_ok, r_ok;
    if (rst) begin
      q.delete();
      exp_dout    = 8'h00;
      model_valid = 1'b1;
    end else if (model_valid) begin
      w_ok = wr && (q.size() < 8);
      r_ok = rd && (q.size() > 0);
      if (r_ok) exp_dout = q.pop_front();
      if (w_ok) q.push_back(d_in);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_empty", {7'b0, empty}, {7'b0, q.size() == 0});
      check("model_full",  {7'b0, full},  {7'b0, q.size() == 8});
      check("model_dout",  d_out, exp_dout);
    end
  end

  // One clock: drive inputs, take the edge, settle just after it.
  task automatic step(input logic r, input logic w, input logic rdq, input logic [7:0] d);
    rst = r; wr = w; rd = rdq; d_in = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fill_data [8];
  logic [7:0] sim_data  [8];
  logic [7:0] wrap_data [8];

  initial begin
    fill_data[0] = 8'h24; fill_data[1] = 8'h81; fill_data[2] = 8'h09; fill_data[3] = 8'h63;
    fill_data[4] = 8'h0D; fill_data[5] = 8'h8D; fill_data[6] = 8'h65; fill_data[7] = 8'h12;

    // Reset held two edges with both requests active.
    step(1'b1, 1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 1'b1, 8'hAA);
    check("rst_empty", {7'b0, empty}, 8'd1);
    check("rst_full",  {7'b0, full},  8'd0);
    check("rst_dout",  d_out, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("rst_nothing_stored", {7'b0, empty}, 8'd1);
    check("rst_dout_hold", d_out, 8'h00);

    // Fill.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, fill_data[i]);
      if (i == 0) check("fill_empty_1st", {7'b0, empty}, 8'd0);
      if (i == 6) check("fill_full_7th",  {7'b0, full},  8'd0);
      if (i == 7) check("fill_full_8th",  {7'b0, full},  8'd1);
    end

    // Overflow attempt.
    step(1'b0, 1'b1, 1'b0, 8'hFF);
    check("ovf_full", {7'b0, full}, 8'd1);

    // Drain.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("drain_dout", d_out, fill_data[i]);
      if (i == 0) check("drain_full_1st",  {7'b0, full},  8'd0);
      if (i == 7) check("drain_empty_8th", {7'b0, empty}, 8'd1);
    end

    // Underflow.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("udf_dout_hold", d_out, 8'h12);
      check("udf_empty", {7'b0, empty}, 8'd1);
    end

    // Simultaneous read/write from empty.
    for (int i = 0; i < 8; i++) begin
      sim_data[i] = 8'($urandom);
      step(1'b0, 1'b1, 1'b1, sim_data[i]);
      check("sim_empty", {7'b0, empty}, 8'd0);
      check("sim_full",  {7'b0, full},  8'd0);
      if (i == 0) check("sim_dout_first", d_out, 8'h12);
      else        check("sim_dout_lag",   d_out, sim_data[i-1]);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("sim_last", d_out, sim_data[7]);
    check("sim_empty_end", {7'b0, empty}, 8'd1);

    // Wrap: 5 in/out, then 8 in/out crossing the pointer rollover.
    for (int i = 0; i < 5; i++) begin
      wrap_data[i] = 8'($urandom);
      step(1'b0, 1'b1, 1'b0, wrap_data[i]);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("wrap5_dout", d_out, wrap_data[i]);
    end
    for (int i = 0; i < 8; i++) begin
      wrap_data[i] = 8'($urandom);
      step(1'b0, 1'b1, 1'b0, wrap_data[i]);
    end
    check("wrap_full", {7'b0, full}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("wrap8_dout", d_out, wrap_data[i]);
    end
    check("wrap_empty", {7'b0, empty}, 8'd1);

    // Mid-operation reset discards queued data.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h77);
    check("midrst_empty", {7'b0, empty}, 8'd1);
    check("midrst_full",  {7'b0, full},  8'd0);
    check("midrst_dout",  d_out, 8'h00);

    // Random traffic, model-checked every cycle, with rare resets.
    for (int n = 0; n < 3000; n++) begin
      logic bias;
      bias = ((n / 200) % 2) == 0;
      step(($urandom_range(0, 149) == 0),
           bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           8'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
